clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider; successor to the single fixed 1 Hz divider.
- Generates NUM_CH independent divided-clock levels plus one-cycle tick strobes from one fast clock.
- Divisor and high-time are runtime-programmable per channel via a shared write port.
- New settings take effect only at a period boundary, so outputs never glitch.
- Feeds display refresh, debouncers and slow state machines on the board.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 27, counter, divisor and high-time width in bits.
- DEF_DIV, 100_000_000, divisor loaded at reset (period in clk_in cycles).
- DEF_HIGH, 50_000_000, high-time loaded at reset (clk_out high cycles per period).

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable, level.
- wr_en  in  1  write strobe for the channel selected by wr_ch.
- wr_ch  in  max(1,clog2(NUM_CH))  target channel; values >= NUM_CH are ignored.
- wr_div  in  CNT_W  new divisor D.
- wr_high  in  CNT_W  new high-time H.
- clk_out  out  NUM_CH  divided clock level per channel, registered.
- tick  out  NUM_CH  one-cycle pulse at the start of each period, registered.
- pend  out  NUM_CH  1 = written settings are waiting to be applied.

Behaviour:
- Per-channel state: cnt, active D_q/H_q, pending D_p/H_p, pend flag, run flag.
- Reset (async, immediate):
  - cnt=0, run=0, clk_out=0, tick=0, pend=0.
  - D_q=DEF_DIV, H_q=DEF_HIGH.
- Clamping, applied when settings move from pending to active:
  - D_eff = max(D,2).
  - H_eff = min(H, D_eff).
  - H=0 gives a constantly low output; H>=D gives a constantly high output (tick still pulses).
- Write port:
  - When wr_en=1 and wr_ch<NUM_CH, D_p/H_p are captured and pend[wr_ch] is set on that edge.
  - A second write before apply overwrites the pending values; no error is raised.
- Apply of pending settings (pend cleared on the same edge):
  - Running channel: at the wrap edge (cnt==D_q-1), so the new period starts with the new values.
  - Stopped channel (run=0): at the next edge.
  - A write to the same channel on its wrap edge is not applied at that wrap; it stays pending until the following wrap.
- Enable edges:
  - en=0 at an edge: run<=0, cnt<=0, clk_out<=0, tick<=0; pending values are still applied.
  - en=1 while run=0: run<=1, cnt<=0, tick<=1, clk_out<=(0 >= D_q-H_q).
  - The first period therefore starts the cycle after en is sampled high.
- Running (run=1, en=1):
  - cnt <= (cnt==D_q-1) ? 0 : cnt+1.
  - tick <= (next cnt==0).
  - clk_out <= (next cnt >= D_q-H_q), so the low phase precedes the high phase.
  - Period is exactly D_eff cycles; high-time is exactly H_eff cycles.
- Width rules:
  - All compares are unsigned CNT_W bits.
  - D_q-H_q cannot underflow because H is clamped to D.
  - cnt never exceeds D_q-1.
- Channel independence: channels share only clk_in, rst and the write port; no cross-channel phase relation unless enabled on the same edge.
- Reset mid-period: all outputs drop on rst assertion, without waiting for a clock edge. After release, the channel restarts from the defaults on the first edge with en=1.

Test Plan:
- Reset, then write ch0 D=4 H=2 with en=0, then en[0]=1 -> pend[0] clears one cycle after the write. clk_out[0] = 0,0,1,1 repeating, tick[0] high on every cnt=0 cycle (period 4).
- ch1 running D=5 H=1, write D=3 H=3 mid-period -> current 5-cycle period completes (one high cycle at cnt=4). Next period is 3 cycles with clk_out constantly 1, ticks every 3 cycles, pend[1] high until the wrap.
- Write D=0 H=7 to ch2, enable -> clamped to D=2 H=2: clk_out[2] constant 1, tick[2] every 2 cycles. Then write D=6 H=0 -> clk_out[2] constant 0, tick every 6 cycles.
- Write with wr_ch=NUM_CH while all channels run -> no pend bit sets and all outputs are unchanged. Two writes to ch3 before its wrap -> only the second setting is applied.
- Deassert en[0] mid-period -> next edge cnt=0, clk_out[0]=0, tick[0]=0. Reassert -> tick[0]=1 the cycle after en is sampled, full new period follows.
- Assert rst asynchronously mid-high phase with DEF parameters overridden to DEF_DIV=10, DEF_HIGH=5 -> clk_out and tick go 0 without a clock edge, pend=0. After release, all channels run at period 10, high 5.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: NUM_CH independent divided clocks and
// period-start ticks from clk_in, with glitch-free settings updates at period boundaries.
module clk_div_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned DEF_DIV  = 100_000_000,
  parameter int unsigned DEF_HIGH = 50_000_000,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  input  logic [CNT_W-1:0]  wr_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam int unsigned DEF_D = (DEF_DIV < 2) ? 2 : DEF_DIV;
  localparam int unsigned DEF_H = (DEF_HIGH > DEF_D) ? DEF_D : DEF_HIGH;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt, d_q, h_q, d_p, h_p;
    logic [CNT_W-1:0] d_cl, d_use, h_use, nxt;
    logic             run, pend_q, clk_q, tick_q;
    logic             wr_hit, wrap, apply;

    // Settings applied on this edge already govern this edge's outputs,
    // so a wrap or a restart begins its period with the new values.
    always_comb begin
      wr_hit = wr_en && (wr_ch == CH_W'(g));
      wrap   = run && (cnt == d_q - CNT_W'(1));
      apply  = pend_q && (!run || !en[g] || wrap);
      d_cl   = (d_p < CNT_W'(2)) ? CNT_W'(2) : d_p;
      d_use  = apply ? d_cl : d_q;
      h_use  = apply ? ((h_p > d_cl) ? d_cl : h_p) : h_q;
      nxt    = wrap ? '0 : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        run    <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        d_q    <= CNT_W'(DEF_D);
        h_q    <= CNT_W'(DEF_H);
        d_p    <= '0;
        h_p    <= '0;
      end else begin
        if (apply) begin
          d_q <= d_use;
          h_q <= h_use;
        end
        // A write landing on an apply edge stays pending for the next boundary.
        if (wr_hit) begin
          d_p    <= wr_div;
          h_p    <= wr_high;
          pend_q <= 1'b1;
        end else if (apply) begin
          pend_q <= 1'b0;
        end
        if (!en[g]) begin
          run    <= 1'b0;
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (!run) begin
          run    <= 1'b1;
          cnt    <= '0;
          tick_q <= 1'b1;
          clk_q  <= ((d_use - h_use) == '0);
        end else begin
          cnt    <= nxt;
          tick_q <= (nxt == '0);
          clk_q  <= (nxt >= (d_use - h_use));
        end
      end
    end

    assign clk_out[g] = clk_q;
    assign tick[g]    = tick_q;
    assign pend[g]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi: table-driven ch0 vectors plus
// hand-written sequences for retiming, clamping, write-port and reset corners.
module tb_clk_div_multi;

  localparam int unsigned NUM_CH = 5;
  localparam int unsigned CNT_W  = 8;

  logic              clk_in = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [2:0]        wr_ch;
  logic [CNT_W-1:0]  wr_div, wr_high;
  logic [NUM_CH-1:0] clk_out, tick, pend;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (10),
    .DEF_HIGH(5)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .wr_high(wr_high),
    .clk_out(clk_out),
    .tick   (tick),
    .pend   (pend)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0] en;
    logic       wr_en;
    logic [2:0] wr_ch;
    logic [7:0] wr_div;
    logic [7:0] wr_high;
    logic [4:0] clk;
    logic [4:0] tick;
    logic [4:0] pend;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic cyc(input string nm, input int ch, input logic ec, input logic et, input logic ep);
    step();
    chk({nm, ".clk"},  32'(clk_out[ch]), 32'(ec));
    chk({nm, ".tick"}, 32'(tick[ch]),    32'(et));
    chk({nm, ".pend"}, 32'(pend[ch]),    32'(ep));
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] d, input logic [7:0] h);
    wr_en = 1'b1; wr_ch = ch; wr_div = d; wr_high = h;
  endtask

  initial begin
    rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
    #2;
    chk("rst.clk",  32'(clk_out), 32'd0);
    chk("rst.tick", 32'(tick),    32'd0);
    chk("rst.pend", 32'(pend),    32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // ch0 D=4 H=2: program while stopped, run, then stop/restart mid-high-phase
    tbl.push_back('{5'd0, 1'b1, 3'd0, 8'd4, 8'd2, 5'd0, 5'd0, 5'd1});
    tbl.push_back('{5'd0, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd1, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd1, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd1, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd0, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd0, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd1, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd1, 5'd0, 5'd0});
    tbl.push_back('{5'd1, 1'b0, 3'd0, 8'd0, 8'd0, 5'd0, 5'd1, 5'd0});
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; wr_en = tbl[i].wr_en; wr_ch = tbl[i].wr_ch;
      wr_div = tbl[i].wr_div; wr_high = tbl[i].wr_high;
      step();
      chk($sformatf("vec%0d.clk", i),  32'(clk_out), 32'(tbl[i].clk));
      chk($sformatf("vec%0d.tick", i), 32'(tick),    32'(tbl[i].tick));
      chk($sformatf("vec%0d.pend", i), 32'(pend),    32'(tbl[i].pend));
    end
    wr_en = 1'b0;

    // ch1: D=5 H=1 running, rewrite to D=3 H=3 mid-period
    wr(3'd1, 8'd5, 8'd1); cyc("c1s0", 1, 0, 0, 1);
    wr_en = 1'b0;         cyc("c1s1", 1, 0, 0, 0);
    en[1] = 1'b1;         cyc("c1s2", 1, 0, 1, 0);
    wr(3'd1, 8'd3, 8'd3); cyc("c1s3", 1, 0, 0, 1);
    wr_en = 1'b0;         cyc("c1s4", 1, 0, 0, 1);
    cyc("c1s5", 1, 0, 0, 1);
    cyc("c1s6", 1, 1, 0, 1);
    cyc("c1s7", 1, 1, 1, 0);
    cyc("c1s8", 1, 1, 0, 0);
    cyc("c1s9", 1, 1, 0, 0);
    cyc("c1s10", 1, 1, 1, 0);
    cyc("c1s11", 1, 1, 0, 0);
    cyc("c1s12", 1, 1, 0, 0);
    cyc("c1s13", 1, 1, 1, 0);

    // ch2: D=0 H=7 clamps to D=2 H=2, then D=6 H=0
    wr(3'd2, 8'd0, 8'd7);        cyc("c2s0", 2, 0, 0, 1);
    wr_en = 1'b0; en[2] = 1'b1;  cyc("c2s1", 2, 1, 1, 0);
    cyc("c2s2", 2, 1, 0, 0);
    cyc("c2s3", 2, 1, 1, 0);
    wr(3'd2, 8'd6, 8'd0);        cyc("c2s4", 2, 1, 0, 1);
    wr_en = 1'b0;                cyc("c2s5", 2, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc($sformatf("c2lo%0d", i), 2, 0, 0, 0);
    cyc("c2s11", 2, 0, 1, 0);

    // ch3/ch4 on defaults, invalid channel write, then double write to ch3
    en[3] = 1'b1; en[4] = 1'b1;  cyc("c3s0", 3, 0, 1, 0);
    wr(3'd5, 8'd2, 8'd1);        cyc("c3s1", 3, 0, 0, 0);
    chk("badch.pend", 32'(pend), 32'd0);
    wr(3'd3, 8'd4, 8'd1);        cyc("c3s2", 3, 0, 0, 1);
    chk("badch.pend_late", 32'(pend), 32'h08);
    wr_en = 1'b0;                cyc("c3s3", 3, 0, 0, 1);
    wr(3'd3, 8'd3, 8'd2);        cyc("c3s4", 3, 0, 0, 1);
    wr_en = 1'b0;
    for (int i = 5; i < 10; i++) cyc($sformatf("c3s%0d", i), 3, 1, 0, 1);
    cyc("c3s10", 3, 0, 1, 0);
    chk("c4.tick_def", 32'(tick[4]), 32'd1);
    cyc("c3s11", 3, 1, 0, 0);
    cyc("c3s12", 3, 1, 0, 0);
    cyc("c3s13", 3, 0, 1, 0);

    // asynchronous reset mid-cycle with a pending write outstanding
    wr(3'd0, 8'd7, 8'd3); step(); wr_en = 1'b0;
    chk("pre.pend0", 32'(pend[0]),    32'd1);
    chk("pre.clk1",  32'(clk_out[1]), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst.clk",  32'(clk_out), 32'd0);
    chk("arst.tick", 32'(tick),    32'd0);
    chk("arst.pend", 32'(pend),    32'd0);
    en = '1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 21; k++) begin
      step();
      chk($sformatf("post%0d.clk", k),  32'(clk_out), ((k % 10) >= 5) ? 32'h1f : 32'd0);
      chk($sformatf("post%0d.tick", k), 32'(tick),    ((k % 10) == 0) ? 32'h1f : 32'd0);
      chk($sformatf("post%0d.pend", k), 32'(pend),    32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
